// File: rtl/ui_pkg.sv
// rtl/ui_pkg.sv - shared state encoding and default tick constants for the button UI
package ui_pkg;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHORT = 2'd2,
    ST_LONG  = 2'd3
  } ui_state_e;

  // 100 MHz build: 20 ms long press, 5 ms repeat interval
  localparam int LONG_PRESS_TICKS_DEF = 2000000;
  localparam int REPEAT_TICKS_DEF     = 500000;

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - loadable up-counter with clear, enable and terminal-count lookahead
module hold_timer #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 255,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             term_next
);

  localparam logic [WIDTH:0] TERM = (WIDTH+1)'(TERMINAL);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH:0]   cnt_inc;
  logic             at_term;

  assign cnt_inc   = {1'b0, cnt_q} + (WIDTH+1)'(1);
  // term_next: the next enabled increment lands exactly on TERMINAL
  assign term_next = (cnt_inc == TERM);
  assign at_term   = ({1'b0, cnt_q} == TERM);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      if (SATURATE) begin
        if (!at_term) cnt_q <= cnt_inc[WIDTH-1:0];
      end else if (term_next) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_inc[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - turns a debounced button level into press/short/long/repeat/release pulses
module button_event_decoder
  import ui_pkg::*;
#(
  parameter int LONG_PRESS_TICKS = LONG_PRESS_TICKS_DEF,
  parameter int REPEAT_TICKS     = REPEAT_TICKS_DEF,
  parameter bit REPEAT_EN        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic held
);

  localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);
  localparam int REP_W  = $clog2(REPEAT_TICKS + 1);

  ui_state_e state_q, state_d;
  logic      press_d, short_d, long_d, rep_d, rel_d, held_d;
  logic      hold_load, hold_en, hold_term_next;
  logic      rep_clr, rep_en, rep_term_next;

  hold_timer #(
    .WIDTH    (HOLD_W),
    .TERMINAL (LONG_PRESS_TICKS),
    .SATURATE (1'b1)
  ) u_hold_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .load      (hold_load),
    .load_val  (HOLD_W'(1)),
    .en        (hold_en),
    .term_next (hold_term_next)
  );

  hold_timer #(
    .WIDTH    (REP_W),
    .TERMINAL (REPEAT_TICKS),
    .SATURATE (1'b0)
  ) u_rep_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (rep_clr),
    .load      (1'b0),
    .load_val  ('0),
    .en        (rep_en),
    .term_next (rep_term_next)
  );

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    rep_d     = 1'b0;
    rel_d     = 1'b0;
    hold_load = 1'b0;
    hold_en   = 1'b0;
    rep_clr   = 1'b0;
    rep_en    = 1'b0;
    case (state_q)
      ST_ARM: begin
        if (!btn_in) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (btn_in) begin
          press_d   = 1'b1;
          hold_load = 1'b1;
          state_d   = ST_SHORT;
        end
      end
      ST_SHORT: begin
        // a low sample wins over the threshold on the same sample
        if (!btn_in) begin
          short_d = 1'b1;
          rel_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          hold_en = 1'b1;
          if (hold_term_next) begin
            long_d  = 1'b1;
            rep_clr = 1'b1;
            state_d = ST_LONG;
          end
        end
      end
      ST_LONG: begin
        if (!btn_in) begin
          rel_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          hold_en = 1'b1;
          rep_en  = 1'b1;
          rep_d   = rep_term_next && REPEAT_EN;
        end
      end
      default: state_d = ST_ARM;
    endcase
    held_d = (state_d == ST_SHORT) || (state_d == ST_LONG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ARM;
      press_pulse   <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_d;
      press_pulse   <= press_d;
      short_press   <= short_d;
      long_press    <= long_d;
      repeat_pulse  <= rep_d;
      release_pulse <= rel_d;
      held          <= held_d;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench for button_event_decoder (repeat enabled and disabled)
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;

  logic p1, s1, l1, r1, rl1, h1;
  logic p0, s0, l0, r0, rl0, h0;

  typedef struct {
    int         cyc;
    logic [5:0] e1;
    logic [5:0] e0;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state: waiting-for-release after reset, and length of current hold
  bit armed = 1'b0;
  int len   = 0;

  button_event_decoder #(.LONG_PRESS_TICKS(L), .REPEAT_TICKS(R), .REPEAT_EN(1'b1)) dut_rep (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .press_pulse(p1), .short_press(s1), .long_press(l1),
    .repeat_pulse(r1), .release_pulse(rl1), .held(h1)
  );

  button_event_decoder #(.LONG_PRESS_TICKS(L), .REPEAT_TICKS(R), .REPEAT_EN(1'b0)) dut_norep (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .press_pulse(p0), .short_press(s0), .long_press(l0),
    .repeat_pulse(r0), .release_pulse(rl0), .held(h0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic model(input logic r, input logic b, output logic [5:0] e1, output logic [5:0] e0);
    logic p, s, lp, rp, rl, h;
    p = 0; s = 0; lp = 0; rp = 0; rl = 0; h = 0;
    if (r) begin
      armed = 1'b0;
      len   = 0;
    end else if (!armed) begin
      if (!b) armed = 1'b1;
    end else if (b) begin
      len = len + 1;
      p   = (len == 1);
      lp  = (len == L);
      rp  = (len > L) && (((len - L) % R) == 0);
      h   = 1'b1;
    end else begin
      if (len > 0) begin
        rl = 1'b1;
        s  = (len < L);
      end
      len = 0;
    end
    e1 = {p, s, lp, rp, rl, h};
    e0 = {p, s, lp, 1'b0, rl, h};
  endtask

  task automatic step(input logic r, input logic b);
    exp_t t;
    rst    = r;
    btn_in = b;
    model(r, b, t.e1, t.e0);
    t.cyc = edge_cnt + 1;
    sb_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n, input int lows);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    for (int i = 0; i < lows; i++) step(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t        t;
    logic [5:0]  got1, got0;
    while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
      t    = sb_q.pop_front();
      got1 = {p1, s1, l1, r1, rl1, h1};
      got0 = {p0, s0, l0, r0, rl0, h0};
      n_checks++;
      if (got1 !== t.e1) begin
        n_fail++;
        $display("FAIL outputs_rep_en1 cyc=%0d got=%b exp=%b {press,short,long,repeat,release,held}",
                 t.cyc, got1, t.e1);
      end
      n_checks++;
      if (got0 !== t.e0) begin
        n_fail++;
        $display("FAIL outputs_rep_en0 cyc=%0d got=%b exp=%b {press,short,long,repeat,release,held}",
                 t.cyc, got0, t.e0);
      end
    end
  end

  initial begin
    int budget;
    rst    = 1'b1;
    btn_in = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    hold(3, 2);
    hold(7, 2);
    hold(8, 2);
    hold(1, 1);
    hold(20, 3);
    // button held through reset, then released and pressed again
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    hold(10, 1);
    hold(3, 2);
    // reset lands on the fifth sample of a hold and the button stays down
    hold(4, 0);
    step(1'b1, 1'b1);
    hold(3, 2);
    hold(2, 1);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        step(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        hold($urandom_range(1, 25), $urandom_range(1, 3));
      end
    end
    step(1'b0, 1'b0);
    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #6;
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
